// File: rtl/ps2_key_event.sv
// PS/2 scan-code-set-2 key event decoder with modifier tracking and event FIFO.
// Optional ASCII translation is built when PS2_ASCII_EN is defined.
module ps2_key_event #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_code,
  input  logic       ps2_code_new,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_ext,
  output logic       out_brk,
  output logic [7:0] out_code,
  output logic [7:0] out_ascii,
  output logic       shift_held,
  output logic       ctrl_held,
  output logic       caps_on,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  state_t      state_r;
  logic [2:0]  skip_cnt_r;
  logic        prev_r;
  logic        caps_down_r;
  logic [17:0] mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;

  logic        accept_s;
  logic        emit_s;
  logic        ext_s;
  logic        brk_s;
  logic [7:0]  ascii_s;
  logic [AW:0] count_s;
  logic        full_s;
  logic        pop_s;
  logic        push_s;

`ifdef PS2_ASCII_EN
  // Shift and Caps are the values held before this byte's own modifier update.
  function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic shift,
                                          input logic caps);
    logic [7:0] letter;
    logic [7:0] digit;
    logic [7:0] sym;
    logic [7:0] res;
    letter = 8'h00;
    digit  = 8'h00;
    sym    = 8'h00;
    res    = 8'h00;
    case (code)
      8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
      8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
      8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
      8'h45: begin digit = 8'h30; sym = 8'h29; end
      8'h16: begin digit = 8'h31; sym = 8'h21; end
      8'h1E: begin digit = 8'h32; sym = 8'h40; end
      8'h26: begin digit = 8'h33; sym = 8'h23; end
      8'h25: begin digit = 8'h34; sym = 8'h24; end
      8'h2E: begin digit = 8'h35; sym = 8'h25; end
      8'h36: begin digit = 8'h36; sym = 8'h5E; end
      8'h3D: begin digit = 8'h37; sym = 8'h26; end
      8'h3E: begin digit = 8'h38; sym = 8'h2A; end
      8'h46: begin digit = 8'h39; sym = 8'h28; end
      8'h29: res = 8'h20;
      8'h5A: res = 8'h0D;
      8'h66: res = 8'h08;
      default: res = 8'h00;
    endcase
    if (letter != 8'h00) begin
      res = (shift ^ caps) ? (letter - 8'h20) : letter;
    end else if (digit != 8'h00) begin
      res = shift ? sym : digit;
    end
    return res;
  endfunction
`endif

  assign accept_s = ps2_code_new & ~prev_r;
  assign count_s  = wr_ptr_r - rd_ptr_r;
  assign full_s   = (count_s == FULL_CNT);
  assign out_valid = (wr_ptr_r != rd_ptr_r);
  assign pop_s    = out_valid & out_ready;
  assign push_s   = emit_s & (~full_s | pop_s);
  assign {out_ext, out_brk, out_code, out_ascii} = mem_r[rd_ptr_r[AW-1:0]];

  // Emit decode: which accepted byte completes a key sequence, and its flags.
  always_comb begin
    emit_s = 1'b0;
    ext_s  = 1'b0;
    brk_s  = 1'b0;
    if (accept_s) begin
      case (state_r)
        IDLE: begin
          case (ps2_code)
            8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: emit_s = 1'b0;
            default: emit_s = 1'b1;
          endcase
        end
        EXT: begin
          case (ps2_code)
            8'hF0, 8'hE0: emit_s = 1'b0;
            default: begin emit_s = 1'b1; ext_s = 1'b1; end
          endcase
        end
        BRK:     begin emit_s = 1'b1; brk_s = 1'b1; end
        EXT_BRK: begin emit_s = 1'b1; ext_s = 1'b1; brk_s = 1'b1; end
        default: emit_s = 1'b0;
      endcase
    end else begin
      emit_s = 1'b0;
    end
  end

  // ASCII for the event being pushed this cycle.
  always_comb begin
    ascii_s = 8'h00;
`ifdef PS2_ASCII_EN
    if (ext_s | brk_s) begin
      ascii_s = 8'h00;
    end else begin
      ascii_s = ascii_of(ps2_code, shift_held, caps_on);
    end
`else
    ascii_s = 8'h00;
`endif
  end

  // Prefix state machine and E1 pause-sequence skip counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      skip_cnt_r <= 3'd0;
      prev_r     <= 1'b0;
    end else begin
      prev_r <= ps2_code_new;
      if (accept_s) begin
        case (state_r)
          IDLE: begin
            case (ps2_code)
              8'hE0:   state_r <= EXT;
              8'hF0:   state_r <= BRK;
              8'hE1:   begin state_r <= SKIP; skip_cnt_r <= 3'd7; end
              default: state_r <= IDLE;
            endcase
          end
          EXT: begin
            case (ps2_code)
              8'hF0:   state_r <= EXT_BRK;
              8'hE0:   state_r <= EXT;
              default: state_r <= IDLE;
            endcase
          end
          SKIP: begin
            if (skip_cnt_r <= 3'd1) begin
              state_r    <= IDLE;
              skip_cnt_r <= 3'd0;
            end else begin
              skip_cnt_r <= skip_cnt_r - 3'd1;
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  // Modifier tracking; caps_down keeps typematic repeats of Caps from re-toggling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_held  <= 1'b0;
      ctrl_held   <= 1'b0;
      caps_on     <= 1'b0;
      caps_down_r <= 1'b0;
    end else if (emit_s) begin
      if (!ext_s && (ps2_code == 8'h12 || ps2_code == 8'h59)) shift_held <= ~brk_s;
      if (ps2_code == 8'h14) ctrl_held <= ~brk_s;
      if (!ext_s && ps2_code == 8'h58) begin
        if (!brk_s) begin
          if (!caps_down_r) caps_on <= ~caps_on;
          caps_down_r <= 1'b1;
        end else begin
          caps_down_r <= 1'b0;
        end
      end
    end
  end

  // Event FIFO; a same-cycle pop frees the slot for a push into a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 18'h0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= {ext_s, brk_s, ps2_code, ascii_s};
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + 1'b1;
      if (emit_s && full_s && !pop_s) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_key_event.sv
// Self-checking bench for ps2_key_event: directed sequences then randomized bytes
// checked against a prefix/queue reference model.
module tb_ps2_key_event;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ps2_code = 8'h00;
  logic       ps2_code_new = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_ext;
  logic       out_brk;
  logic [7:0] out_code;
  logic [7:0] out_ascii;
  logic       shift_held;
  logic       ctrl_held;
  logic       caps_on;
  logic       overflow;

  ps2_key_event #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ps2_code(ps2_code), .ps2_code_new(ps2_code_new),
    .out_valid(out_valid), .out_ready(out_ready), .out_ext(out_ext), .out_brk(out_brk),
    .out_code(out_code), .out_ascii(out_ascii), .shift_held(shift_held),
    .ctrl_held(ctrl_held), .caps_on(caps_on), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46};
  logic [7:0] digit_syms [10]  = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
                                   8'h2A, 8'h28};
  logic [7:0] pool [20] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'h14, 8'h58, 8'h1C, 8'h32,
                            8'h45, 8'h16, 8'h29, 8'h5A, 8'h66, 8'h75, 8'hAA, 8'hFA, 8'h00,
                            8'hFF, 8'h21};

  // Reference model state: pending prefixes, remaining pause bytes, modifiers, event queue.
  logic        m_ext_pend, m_brk_pend;
  int          m_skip;
  logic        m_shift, m_ctrl, m_caps, m_caps_down, m_ovf;
  logic [17:0] exp_q[$];

  function automatic logic [7:0] exp_ascii(input logic [7:0] c, input logic e,
                                           input logic k, input logic sh, input logic cp);
    logic [7:0] r;
    r = 8'h00;
`ifdef PS2_ASCII_EN
    if (!e && !k) begin
      for (int i = 0; i < 26; i++)
        if (letter_codes[i] == c) r = 8'(97 + i - ((sh ^ cp) ? 32 : 0));
      for (int i = 0; i < 10; i++)
        if (digit_codes[i] == c) r = sh ? digit_syms[i] : 8'(48 + i);
      if (c == 8'h29) r = 8'h20;
      if (c == 8'h5A) r = 8'h0D;
      if (c == 8'h66) r = 8'h08;
    end
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_ext_pend = 1'b0; m_brk_pend = 1'b0; m_skip = 0;
    m_shift = 1'b0; m_ctrl = 1'b0; m_caps = 1'b0; m_caps_down = 1'b0; m_ovf = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_emit(input logic e, input logic k, input logic [7:0] c);
    logic [7:0] a;
    a = exp_ascii(c, e, k, m_shift, m_caps);
    if (exp_q.size() < DEPTH) exp_q.push_back({e, k, c, a});
    else m_ovf = 1'b1;
    if (!e && (c == 8'h12 || c == 8'h59)) m_shift = !k;
    if (c == 8'h14) m_ctrl = !k;
    if (!e && c == 8'h58) begin
      if (!k && !m_caps_down) m_caps = !m_caps;
      m_caps_down = !k;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_skip > 0) begin
      m_skip--;
    end else if (!m_ext_pend && !m_brk_pend) begin
      if (b == 8'hE0) m_ext_pend = 1'b1;
      else if (b == 8'hF0) m_brk_pend = 1'b1;
      else if (b == 8'hE1) m_skip = 7;
      else if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) m_skip = 0;
      else model_emit(1'b0, 1'b0, b);
    end else if (m_ext_pend && !m_brk_pend) begin
      if (b == 8'hF0) m_brk_pend = 1'b1;
      else if (b != 8'hE0) begin model_emit(1'b1, 1'b0, b); m_ext_pend = 1'b0; end
    end else begin
      model_emit(m_ext_pend, 1'b1, b);
      m_ext_pend = 1'b0; m_brk_pend = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_mods();
    chk("shift_held", shift_held, m_shift);
    chk("ctrl_held", ctrl_held, m_ctrl);
    chk("caps_on", caps_on, m_caps);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    out_ready = 1'b0;
    ps2_code = b;
    ps2_code_new = 1'b1;
    model_byte(b);
    repeat (hold) @(negedge clk);
    ps2_code_new = 1'b0;
    check_mods();
  endtask

  task automatic pop_check();
    logic [17:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk("valid_empty", out_valid, 1'b0);
    end else begin
      e = exp_q.pop_front();
      chk("valid", out_valid, 1'b1);
      chk("head", {out_ext, out_brk, out_code, out_ascii}, e);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) pop_check();
    @(negedge clk);
    chk("drained_valid", out_valid, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ps2_code_new = 1'b0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic [17:0] e;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_head", {out_ext, out_brk, out_code, out_ascii}, 18'h0);
    check_mods();
    rst = 1'b0;

    // Long level: one event only.
    send_byte(8'h1C, 50);
    drain();

    // Shift make, one-cycle latency, shifted letter, release.
    send_byte(8'h12, 1);
    chk("latency_valid", out_valid, 1'b1);
    send_byte(8'h1C, 2);
    drain();
    send_byte(8'hF0, 1);
    send_byte(8'h12, 1);
    drain();

    // Caps toggle with typematic repeat.
    send_byte(8'h58, 1);
    send_byte(8'h58, 1);
    send_byte(8'hF0, 1);
    send_byte(8'h58, 1);
    send_byte(8'h58, 1);
    drain();

    // Extended make and break, extended ctrl.
    send_byte(8'hE0, 1); send_byte(8'h75, 1);
    send_byte(8'hE0, 1); send_byte(8'hF0, 1); send_byte(8'h75, 1);
    send_byte(8'hE0, 1); send_byte(8'h14, 1);
    send_byte(8'hE0, 1); send_byte(8'hF0, 1); send_byte(8'h14, 1);
    drain();

    // Pause sequence skipped.
    foreach (pool[i]) b = pool[i];
    send_byte(8'hE1, 1); send_byte(8'h14, 1); send_byte(8'h77, 1); send_byte(8'hE1, 1);
    send_byte(8'hF0, 1); send_byte(8'h14, 1); send_byte(8'hF0, 1); send_byte(8'h77, 1);
    send_byte(8'h1C, 1);
    drain();

    // Full FIFO with a simultaneous pop and push: no drop.
    send_byte(8'h15, 1); send_byte(8'h1D, 1); send_byte(8'h24, 1); send_byte(8'h2D, 1);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("full_head", {out_ext, out_brk, out_code, out_ascii}, e);
    ps2_code = 8'h2C; ps2_code_new = 1'b1; out_ready = 1'b1;
    model_byte(8'h2C);
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    ps2_code_new = 1'b0;
    check_mods();
    drain();

    // Five makes with no consumer: fourth is the last kept.
    send_byte(8'h15, 1); send_byte(8'h1D, 1); send_byte(8'h24, 1);
    send_byte(8'h2D, 1); send_byte(8'h2C, 1);
    drain();
    check_mods();

    // Reset in the middle of an E0 sequence.
    send_byte(8'hE0, 1);
    do_reset();
    check_mods();
    send_byte(8'h75, 1);
    drain();

    // Randomized bytes with interleaved pops.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        pop_check();
      end else begin
        if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 255));
        else b = pool[$urandom_range(0, 19)];
        send_byte(b, $urandom_range(1, 3));
      end
    end
    drain();
    check_mods();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
